// File: rtl/var_shift_reg.sv
// var_shift_reg: WIDTH-bit register that loads a parallel input or shifts its own value by a run-time distance.
// Latency: one clock from in/clr/shift to q; q comes straight from a flop.
// Backpressure: none; every input is sampled on every edge and there is no handshake.
//
// Ports:
//   clk   - rising-edge clock
//   clr   - synchronous active-high clear; has priority over all other inputs
//   dir   - 0 = shift toward MSB, 1 = shift toward LSB
//   en    - 1 = shift the held value, 0 = load in
//   in    - parallel load data (ignored while en=1)
//   shift - signed shift distance per enabled cycle (negative or zero holds q)
//   q     - registered state
//
// Build option: define VAR_SHIFT_ROTATE_EN to turn enabled shifts into rotates.
// The distance is then taken mod WIDTH. Negative distances still hold q.

module var_shift_reg #(
    parameter int WIDTH   = 32,
    parameter int SHIFT_W = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               dir,
    input  logic               en,
    input  logic [WIDTH-1:0]   in,
    input  logic [SHIFT_W-1:0] shift,
    output logic [WIDTH-1:0]   q
);

    localparam int LOG_W = $clog2(WIDTH);

    // The range check needs at least one bit between the barrel-stage
    // bits and the sign bit.
    if (WIDTH < 2 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("var_shift_reg: WIDTH must be a power of two in 2..64");
    end
    if (SHIFT_W < LOG_W + 2) begin : g_bad_shift_w
        $error("var_shift_reg: SHIFT_W too narrow for WIDTH");
    end

    // Decode the shift distance.
    logic             shift_neg;
    logic [LOG_W-1:0] shift_amt;

    assign shift_neg = shift[SHIFT_W-1];
    assign shift_amt = shift[LOG_W-1:0];

`ifdef VAR_SHIFT_ROTATE_EN
    // A rotate wraps, so the bits above the barrel stages are meaningless.
    logic unused_shift_hi;
    assign unused_shift_hi = ^shift[SHIFT_W-2:LOG_W];
`else
    // Any set bit between the barrel stages and the sign bit means the
    // distance is at least WIDTH, so every bit is shifted out.
    logic shift_too_big;
    assign shift_too_big = |shift[SHIFT_W-2:LOG_W];
`endif

    // Barrel shifter with log2(WIDTH) stages.
    // Stage i moves the value by 2**i positions when bit i of the distance is set.
    logic [WIDTH-1:0] barrel;

    always_comb begin
        barrel = q;
        for (int i = 0; i < LOG_W; i++) begin
            if (shift_amt[i]) begin
`ifdef VAR_SHIFT_ROTATE_EN
                if (dir) begin
                    barrel = (barrel >> (2 ** i)) | (barrel << (WIDTH - 2 ** i));
                end else begin
                    barrel = (barrel << (2 ** i)) | (barrel >> (WIDTH - 2 ** i));
                end
`else
                if (dir) begin
                    barrel = barrel >> (2 ** i);
                end else begin
                    barrel = barrel << (2 ** i);
                end
`endif
            end
        end
    end

    // Select the value for an enabled cycle.
    // A zero distance needs no special case: the barrel passes q through.
    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = barrel;
        if (shift_neg) begin
            shifted = q;
`ifndef VAR_SHIFT_ROTATE_EN
        end else if (shift_too_big) begin
            shifted = '0;
`endif
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (!en) begin
            q <= in;
        end else begin
            q <= shifted;
        end
    end

endmodule

// File: tb/tb_var_shift_reg.sv
// tb_var_shift_reg: scoreboard bench for var_shift_reg (WIDTH=32, SHIFT_W=32).
// Each stimulus cycle pushes its expected q. The value is popped and compared one edge later.
// Directed vectors carry literal expectations. Random vectors use an arithmetic reference model.

module tb_var_shift_reg;

    logic               clk;
    logic               clr;
    logic               dir;
    logic               en;
    logic [31:0]        in;
    logic signed [31:0] shift;
    logic [31:0]        q;

    int checks;
    int errors;

    logic [31:0] exp_q[$];
    logic [31:0] mdl;

    var_shift_reg #(.WIDTH(32), .SHIFT_W(32)) dut (
        .clk   (clk),
        .clr   (clr),
        .dir   (dir),
        .en    (en),
        .in    (in),
        .shift (shift),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Arithmetic reference model. It is independent of the barrel-shifter structure.
    function automatic logic [31:0] model(input logic [31:0] prev, input logic c,
                                          input logic e, input logic d,
                                          input logic [31:0] din,
                                          input logic signed [31:0] s);
        int n;
        if (c) return 32'h0;
        if (!e) return din;
        if (s <= 0) return prev;
`ifdef VAR_SHIFT_ROTATE_EN
        n = int'(s) % 32;
        if (n == 0) return prev;
        return d ? ((prev >> n) | (prev << (32 - n))) : ((prev << n) | (prev >> (32 - n)));
`else
        if (s >= 32) return 32'h0;
        n = int'(s);
        return d ? (prev >> n) : (prev << n);
`endif
    endfunction

    // Drive one cycle, push its expectation, then pop and compare after the edge.
    task automatic step(input string tag, input logic c, input logic e, input logic d,
                        input logic [31:0] din, input logic signed [31:0] s,
                        input logic [31:0] want);
        logic [31:0] w;
        @(negedge clk);
        clr   = c;
        en    = e;
        dir   = d;
        in    = din;
        shift = s;
        exp_q.push_back(want);
        mdl = want;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            w = exp_q.pop_front();
            chk(tag, q, w);
        end
    endtask

    localparam logic [31:0] PAT = 32'h7105c1a6;
    localparam logic [31:0] B   = 32'h80000001;

    initial begin
        logic c, e, d;
        logic [31:0] din;
        logic signed [31:0] s;
        logic [31:0] w;

        checks = 0;
        errors = 0;
        clr = 1'b0; en = 1'b0; dir = 1'b0; in = '0; shift = '0;

        // Reset priority: clr wins over an enabled shift.
        step("preload",   0, 0, 0, 32'hffffffff, 0, 32'hffffffff);
        step("clr_shift", 1, 1, 0, 32'hffffffff, 3, 32'h00000000);
        step("clr_hold",  1, 0, 1, 32'hdeadbeef, 7, 32'h00000000);

        // Load tracking.
        step("load1", 0, 0, 0, PAT,          0, PAT);
        step("load2", 0, 0, 0, 32'h12345678, 5, 32'h12345678);

        // Left accumulation. in changes to show it is ignored while en=1.
        step("ld_l",   0, 0, 0, PAT,          0,  PAT);
        step("left1",  0, 1, 0, 32'hffffffff, 12, 32'h5c1a6000);
        step("left2",  0, 1, 0, 32'h0,        12, 32'ha6000000);
        step("left3",  0, 1, 0, 32'h0,        12, 32'h00000000);

        // Right shift, then zero and negative distances hold q.
        step("ld_r",   0, 0, 0, PAT, 0,  PAT);
        step("right5", 0, 1, 1, PAT, 5,  32'h03882e0d);
        step("zero",   0, 1, 1, PAT, 0,  32'h03882e0d);
        step("neg1",   0, 1, 0, PAT, -1, 32'h03882e0d);
        step("negmin", 0, 1, 1, PAT, 32'sh80000000, 32'h03882e0d);

        // clr in the middle of a shift sequence discards the partial value.
        step("ld_c",   0, 0, 0, PAT, 0, PAT);
        step("sh_c",   0, 1, 0, PAT, 4, 32'h105c1a60);
        step("clr_mid",1, 1, 0, PAT, 4, 32'h00000000);

`ifdef VAR_SHIFT_ROTATE_EN
        step("ld_a",  0, 0, 0, PAT, 0,  PAT);
        step("rotl12",0, 1, 0, PAT, 12, 32'h5c1a6710);
        step("ld_b",  0, 0, 0, PAT, 0,  PAT);
        step("rotr4", 0, 1, 1, PAT, 4,  32'h67105c1a);
        step("ld_c2", 0, 0, 0, PAT, 0,  PAT);
        step("rotr36",0, 1, 1, PAT, 36, 32'h67105c1a);
        step("ld_d",  0, 0, 0, PAT, 0,  PAT);
        step("rot32", 0, 1, 0, PAT, 32, PAT);
`else
        step("ld_a",  0, 0, 0, B, 0,  B);
        step("r31",   0, 1, 1, B, 31, 32'h00000001);
        step("ld_b",  0, 0, 0, B, 0,  B);
        step("l31",   0, 1, 0, B, 31, 32'h80000000);
        step("ld_c2", 0, 0, 0, B, 0,  B);
        step("s32",   0, 1, 0, B, 32, 32'h00000000);
        step("ld_d",  0, 0, 0, B, 0,  B);
        step("s40",   0, 1, 1, B, 40, 32'h00000000);
        step("ld_e",  0, 0, 0, B, 0,  B);
        step("sbig",  0, 1, 1, B, 32'sh00010000, 32'h00000000);
`endif

        // Random mix, checked against the reference model.
        for (int i = 0; i < 300; i++) begin
            c   = ($urandom_range(0, 19) == 0);
            e   = ($urandom_range(0, 3) != 0);
            d   = 1'($urandom_range(0, 1));
            din = $urandom();
            case ($urandom_range(0, 3))
                0:       s = $urandom();
                1:       s = -$signed(32'($urandom_range(1, 40)));
                default: s = $urandom_range(0, 40);
            endcase
            w = model(mdl, c, e, d, din, s);
            step("rand", c, e, d, din, s, w);
        end

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
